// File: rtl/rll_key_pkg.sv
// Shared types and sizing helpers for the RLL key loader.
package rll_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned KEY_BITS_DEF = 32;
    localparam int unsigned WORD_W_DEF   = 8;
    localparam int unsigned NUM_WORDS    = KEY_BITS_DEF / WORD_W_DEF;
    // The checksum is one key-store word wide.
    localparam int unsigned CSUM_W       = WORD_W_DEF;

    // Address must reach NUM_WORDS, the checksum slot.
    function automatic int unsigned addr_width(input int unsigned num_words);
        return (num_words == 0) ? 1 : $clog2(num_words + 1);
    endfunction

endpackage

// File: rtl/rll_key_word_fetch.sv
// Key-store fetch datapath: request/address, timeout, word capture and XOR checksum.
module rll_key_word_fetch
    import rll_key_pkg::*;
#(
    parameter  int unsigned KEY_BITS = 32,
    parameter  int unsigned WORD_W   = 8,
    parameter  int unsigned TIMEOUT  = 16,
    localparam int unsigned NW       = KEY_BITS / WORD_W,
    localparam int unsigned AW       = addr_width(NW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                fetch_i,
    input  logic                mem_valid_i,
    input  logic [WORD_W-1:0]   mem_data_i,
    output logic                mem_req_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [KEY_BITS-1:0] shadow_o,
    output logic                word_done_o,
    output logic                last_word_o,
    output logic                timeout_o,
    output logic                match_o
);

    localparam int unsigned    TW        = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(NW);

    logic [AW-1:0]       addr_q, addr_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [KEY_BITS-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]   csum_q, csum_d;
    logic                accept;

    assign accept      = fetch_i & mem_valid_i;
    assign mem_req_o   = fetch_i;
    assign mem_addr_o  = fetch_i ? addr_q : '0;
    assign shadow_o    = shadow_q;
    assign word_done_o = accept;
    // Level: the word currently on offer is the checksum slot.
    assign last_word_o = (addr_q == LAST_ADDR);
    assign timeout_o   = fetch_i & ~mem_valid_i & (tcnt_q == TW'(TIMEOUT - 1));
    assign match_o     = (acc_q == csum_q);

    // Next-state for address, timeout counter, shadow key, accumulator and checksum.
    always_comb begin
        addr_d   = addr_q;
        tcnt_d   = tcnt_q;
        shadow_d = shadow_q;
        acc_d    = acc_q;
        csum_d   = csum_q;
        if (clear_i) begin
            addr_d   = '0;
            tcnt_d   = '0;
            shadow_d = '0;
            acc_d    = '0;
            csum_d   = '0;
        end else if (accept) begin
            tcnt_d = '0;
            if (last_word_o) begin
                csum_d = mem_data_i;
            end else begin
                for (int unsigned i = 0; i < NW; i++) begin
                    if (addr_q == AW'(i)) begin
                        shadow_d[i*WORD_W +: WORD_W] = mem_data_i;
                    end
                end
                acc_d  = acc_q ^ mem_data_i;
                addr_d = addr_q + AW'(1);
            end
        end else if (fetch_i) begin
            tcnt_d = tcnt_q + TW'(1);
        end else begin
            tcnt_d = '0;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            tcnt_q   <= '0;
            shadow_q <= '0;
            acc_q    <= '0;
            csum_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            tcnt_q   <= tcnt_d;
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            csum_q   <= csum_d;
        end
    end

endmodule

// File: rtl/rll_key_loader.sv
// Loads, verifies and applies the unlock key of an RLL-locked core; gates its outputs until then.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter  int unsigned KEY_BITS  = 32,
    parameter  int unsigned WORD_W    = 8,
    parameter  int unsigned TIMEOUT   = 16,
    parameter  int unsigned MAX_RETRY = 2,
    localparam int unsigned NW        = KEY_BITS / WORD_W,
    localparam int unsigned AW        = addr_width(NW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_valid,
    input  logic [WORD_W-1:0]   mem_data,
    output logic [KEY_BITS-1:0] key_out,
    output logic                key_valid,
    output logic                out_en,
    output logic                busy,
    output logic                err
);

    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t              state_q, state_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic                kv_q, kv_d;
    logic                err_q, err_d;
    logic                clear, fail;
    logic [KEY_BITS-1:0] shadow;
    logic                word_done, last_word, timeout, match;

    rll_key_word_fetch #(
        .KEY_BITS (KEY_BITS),
        .WORD_W   (WORD_W),
        .TIMEOUT  (TIMEOUT)
    ) u_fetch (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .fetch_i     (state_q == FETCH),
        .mem_valid_i (mem_valid),
        .mem_data_i  (mem_data),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .shadow_o    (shadow),
        .word_done_o (word_done),
        .last_word_o (last_word),
        .timeout_o   (timeout),
        .match_o     (match)
    );

    assign key_out   = key_q;
    assign key_valid = kv_q;
    assign out_en    = kv_q;
    assign err       = err_q;
    assign busy      = (state_q == FETCH) || (state_q == CHECK);

    // Sequencing FSM: next state, retry count, committed key and status flags.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        key_d   = key_q;
        kv_d    = kv_q;
        err_d   = err_q;
        clear   = 1'b0;
        fail    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    retry_d = '0;
                    clear   = 1'b1;
                end
            end
            FETCH: begin
                if (word_done && last_word) begin
                    state_d = CHECK;
                end else if (timeout) begin
                    fail = 1'b1;
                end
            end
            CHECK: begin
                if (match) begin
                    key_d   = shadow;
                    kv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    fail = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    key_d   = '0;
                    kv_d    = 1'b0;
                    retry_d = '0;
                    clear   = 1'b1;
                    state_d = FETCH;
                end
            end
            ERROR: begin
                if (start) begin
                    err_d   = 1'b0;
                    retry_d = '0;
                    clear   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        // Timeout and checksum mismatch share one retry path.
        if (fail) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                clear   = 1'b1;
                state_d = FETCH;
            end else begin
                state_d = ERROR;
                err_d   = 1'b1;
                key_d   = '0;
                kv_d    = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            retry_q <= '0;
            key_q   <= '0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            key_q   <= key_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: vector table with scoreboard plus multi-cycle corner sequences.
module tb_rll_key_loader;

    typedef struct {
        logic [31:0] words;
        logic [7:0]  c0;
        logic [7:0]  cr;
        logic [31:0] key;
        logic        e;
        int unsigned att;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_data;
    logic        mem_req;
    logic [2:0]  mem_addr;
    logic [31:0] key_out;
    logic        key_valid, out_en, busy, err;

    logic [7:0]  store [4];
    logic [7:0]  csum0 = '0;
    logic [7:0]  csum_r = '0;
    int unsigned att_cnt = 0;
    int unsigned att_base = 0;
    bit          cs_pend = 1'b0;
    int unsigned viol = 0;
    int unsigned vbase = 0;
    bit          mon_en = 1'b0;
    bit          sb_en = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    vec_t        vec [7];
    vec_t        sb_q [$];
    logic [2:0]  addr_q [$];
    vec_t        e;

    always #5 clk = ~clk;

    rll_key_loader #(
        .KEY_BITS  (32),
        .WORD_W    (8),
        .TIMEOUT   (16),
        .MAX_RETRY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .key_out   (key_out),
        .key_valid (key_valid),
        .out_en    (out_en),
        .busy      (busy),
        .err       (err)
    );

    // Key-store model: checksum slot returns c0 on the first attempt, cr afterwards.
    always_comb begin
        if (mem_addr == 3'd4) mem_data = (att_cnt == att_base) ? csum0 : csum_r;
        else                  mem_data = store[mem_addr[1:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: monitor at negedge, return 1 time unit after the posedge.
    task automatic tick();
        @(negedge clk);
        if (cs_pend) begin
            att_cnt++;
            cs_pend = 1'b0;
        end
        if (mon_en) begin
            if (key_valid !== out_en) viol++;
            if (!key_valid && key_out != 32'h0) viol++;
            if (key_valid && err) viol++;
        end
        if (mem_req === 1'b1 && mem_valid) begin
            if (mem_addr == 3'd4) cs_pend = 1'b1;
            if (sb_en) begin
                if (addr_q.size() > 0) begin
                    chk("addr_seq", {29'd0, mem_addr}, {29'd0, addr_q.pop_front()});
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL addr_extra: got %0d expected no further request", mem_addr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (!(key_valid || err) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no completion expected done/err within 200 cycles", name);
        end
    endtask

    task automatic load(input logic [31:0] w, input logic [7:0] c0, input logic [7:0] cr);
        for (int i = 0; i < 4; i++) store[i] = w[i*8 +: 8];
        csum0    = c0;
        csum_r   = cr;
        att_base = att_cnt;
    endtask

    task automatic push_addrs();
        for (int i = 0; i <= 4; i++) addr_q.push_back(3'(i));
        sb_en = 1'b1;
    endtask

    initial begin
        vec[0] = '{32'h44332211, 8'h44, 8'h44, 32'h44332211, 1'b0, 1};
        vec[1] = '{32'h44332211, 8'h00, 8'h44, 32'h44332211, 1'b0, 2};
        vec[2] = '{32'h44332211, 8'hFF, 8'hFF, 32'h00000000, 1'b1, 3};
        vec[3] = '{32'hF00F5AA5, 8'h00, 8'h00, 32'hF00F5AA5, 1'b0, 1};
        vec[4] = '{32'h08040201, 8'h0E, 8'h0F, 32'h08040201, 1'b0, 2};
        vec[5] = '{32'hEFBEADDE, 8'h00, 8'h23, 32'h00000000, 1'b1, 3};
        vec[6] = '{32'hEFBEADDE, 8'h22, 8'h22, 32'hEFBEADDE, 1'b0, 1};
        load(32'h44332211, 8'h44, 8'h44);

        // Reset state
        repeat (2) tick();
        chk("rst_key_out", key_out, 32'h0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Nominal latency: start in cycle 0, key_valid in cycle 7
        load(32'h44332211, 8'h44, 8'h44);
        start = 1'b1; mem_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_busy", busy, 1);
        chk("lat_mem_req", mem_req, 1);
        chk("lat_addr0", mem_addr, 0);
        repeat (5) tick();
        chk("lat_kv_c6", key_valid, 0);
        chk("lat_key_c6", key_out, 32'h0);
        tick();
        chk("lat_kv_c7", key_valid, 1);
        chk("lat_out_en_c7", out_en, 1);
        chk("lat_key_c7", key_out, 32'h44332211);
        chk("lat_err", err, 0);
        chk("lat_busy_done", busy, 0);

        // Vector table through the result scoreboard
        for (int r = 0; r < 7; r++) begin
            load(vec[r].words, vec[r].c0, vec[r].cr);
            sb_q.push_back(vec[r]);
            vbase = viol;
            start = 1'b1; mem_valid = 1'b1;
            tick();
            start = 1'b0;
            wait_done($sformatf("row%0d_done", r));
            e = sb_q.pop_front();
            chk($sformatf("row%0d_key", r), key_out, e.key);
            chk($sformatf("row%0d_kv", r), key_valid, !e.e);
            chk($sformatf("row%0d_out_en", r), out_en, !e.e);
            chk($sformatf("row%0d_err", r), err, e.e);
            chk($sformatf("row%0d_attempts", r), att_cnt - att_base, e.att);
            chk($sformatf("row%0d_viol", r), viol - vbase, 0);
        end

        // Timeout on word 2, then retry from address 0
        load(32'h44332211, 8'h44, 8'h44);
        start = 1'b1; mem_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        mem_valid = 1'b0;
        repeat (15) tick();
        chk("to_hold_addr", mem_addr, 2);
        tick();
        chk("to_retry_addr", mem_addr, 0);
        chk("to_retry_busy", busy, 1);
        chk("to_retry_err", err, 0);
        mem_valid = 1'b1;
        wait_done("to_done");
        chk("to_key", key_out, 32'h44332211);
        chk("to_attempts", att_cnt - att_base, 1);

        // All attempts stalled
        start = 1'b1; mem_valid = 1'b0;
        tick();
        start = 1'b0;
        repeat (47) tick();
        chk("stall_err_pre", err, 0);
        chk("stall_busy_pre", busy, 1);
        tick();
        chk("stall_err", err, 1);
        chk("stall_key", key_out, 32'h0);
        chk("stall_busy", busy, 0);
        chk("stall_mem_req", mem_req, 0);

        // Reset mid-FETCH after two words
        load(32'h44332211, 8'h44, 8'h44);
        start = 1'b1; mem_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_err_cleared", err, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_mem_req", mem_req, 0);
        chk("mid_key", key_out, 32'h0);
        chk("mid_busy", busy, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_kv", key_valid, 0);
        load(32'h44332211, 8'h44, 8'h44);
        push_addrs();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("mid_done");
        sb_en = 1'b0;
        chk("mid_reload_key", key_out, 32'h44332211);
        chk("mid_addr_left", addr_q.size(), 0);

        // Stray mem_valid with mem_req low, then reload with start noise
        repeat (3) tick();
        chk("stray_kv", key_valid, 1);
        chk("stray_key", key_out, 32'h44332211);
        chk("stray_mem_req", mem_req, 0);
        load(32'hF00F5AA5, 8'h00, 8'h00);
        push_addrs();
        start = 1'b1; mem_valid = 1'b0;
        tick();
        chk("reload_kv_drop", key_valid, 0);
        chk("reload_key_zero", key_out, 32'h0);
        chk("reload_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; mem_valid = 1'b0;
            tick();
            start = 1'b0; mem_valid = 1'b1;
            tick();
        end
        wait_done("reload_done");
        sb_en = 1'b0;
        chk("reload_key", key_out, 32'hF00F5AA5);
        chk("reload_attempts", att_cnt - att_base, 1);
        chk("reload_addr_left", addr_q.size(), 0);
        chk("invariant_total", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
